// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for N accumulator processors sharing one memory bus.
// Grants one requester at a time, tracks transfers and revokes idle grants via a watchdog.
module bus_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [1:0]            op,
    input  logic                  signal,
    output logic [N-1:0]          grant,
    output logic [$clog2(N)-1:0]  owner,
    output logic [3:0]            state,
    output logic                  timeout,
    output logic [15:0]           xfer_count
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_GRANT = 4'b0010;
    localparam logic [3:0] S_XFER  = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    logic [IW-1:0] last_owner;
    logic [WW-1:0] wdog;

    logic [3:0]    state_nx;
    logic [N-1:0]  grant_nx;
    logic [IW-1:0] owner_nx;
    logic [IW-1:0] last_owner_nx;
    logic          timeout_nx;
    logic [15:0]   xfer_count_nx;
    logic [WW-1:0] wdog_nx;

    logic [IW-1:0] pick;
    logic [IW-1:0] idx;

    // Rotating priority: first set request searching upward from last_owner+1.
    always_comb begin
        pick = last_owner;
        idx  = last_owner;
        for (int i = N; i >= 1; i--) begin
            idx = last_owner + IW'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        timeout_nx    = 1'b0;
        xfer_count_nx = xfer_count;
        wdog_nx       = wdog;

        case (state)
            S_IDLE: begin
                grant_nx = '0;
                if (|req) begin
                    owner_nx = pick;
                    grant_nx = N'(1) << pick;
                    wdog_nx  = '0;
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[owner]) begin
                    state_nx      = S_IDLE;
                    grant_nx      = '0;
                    last_owner_nx = owner;
                end else if (op == OP_FETCH || op == OP_SEND) begin
                    state_nx = S_XFER;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    state_nx      = S_IDLE;
                    grant_nx      = '0;
                    last_owner_nx = owner;
                    timeout_nx    = 1'b1;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
            end
            S_XFER: begin
                // Completion wins over a simultaneous request drop.
                if (signal) begin
                    state_nx      = S_DONE;
                    xfer_count_nx = xfer_count + 16'(1);
                end else if (!req[owner]) begin
                    state_nx      = S_IDLE;
                    grant_nx      = '0;
                    last_owner_nx = owner;
                end
            end
            S_DONE: begin
                if (!req[owner]) begin
                    state_nx      = S_IDLE;
                    grant_nx      = '0;
                    last_owner_nx = owner;
                end
            end
            default: begin
                state_nx = S_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IW'(N - 1);
            timeout    <= 1'b0;
            xfer_count <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            timeout    <= timeout_nx;
            xfer_count <= xfer_count_nx;
            wdog       <= wdog_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter plus hand-written watchdog and
// asynchronous-reset sequences.
module tb_bus_arbiter;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_GRANT = 4'b0010;
    localparam logic [3:0] S_XFER  = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [1:0]  op;
    logic        signal;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [3:0]  state;
    logic        timeout;
    logic [15:0] xfer_count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  op;
        logic        signal;
        logic [3:0]  grant;
        logic [3:0]  state;
        logic [1:0]  owner;
        logic        timeout;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[$];

    bus_arbiter #(.N(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .op         (op),
        .signal     (signal),
        .grant      (grant),
        .owner      (owner),
        .state      (state),
        .timeout    (timeout),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [1:0] o, input logic s,
                                input logic [3:0] g, input logic [3:0] st, input logic [1:0] ow,
                                input logic to, input logic [15:0] c);
        vec_t v;
        v.req = r; v.op = o; v.signal = s; v.grant = g;
        v.state = st; v.owner = ow; v.timeout = to; v.count = c;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0]  gbit;
        logic [1:0]  k;
        logic [15:0] cnt;
        int          gcycles;
        int          pulses;

        n_checks = 0;
        n_fail   = 0;

        // Fairness with all requesting; first grant favours requester 0 after reset.
        cnt = 16'd0;
        for (int g = 0; g < 5; g++) begin
            k    = 2'(g % 4);
            gbit = 4'(1) << k;
            add(4'b1111,  2'b00, 1'b0, gbit, S_GRANT, k, 1'b0, cnt);
            add(4'b1111,  2'b01, 1'b0, gbit, S_XFER,  k, 1'b0, cnt);
            cnt = cnt + 16'd1;
            add(4'b1111,  2'b00, 1'b1, gbit, S_DONE,  k, 1'b0, cnt);
            add(4'b1111 & ~gbit, 2'b00, 1'b0, 4'b0000, S_IDLE, k, 1'b0, cnt);
        end
        // Single transfer on requester 2.
        add(4'b0100, 2'b00, 1'b0, 4'b0100, S_GRANT, 2'd2, 1'b0, 16'd5);
        add(4'b0100, 2'b01, 1'b0, 4'b0100, S_XFER,  2'd2, 1'b0, 16'd5);
        add(4'b0100, 2'b00, 1'b1, 4'b0100, S_DONE,  2'd2, 1'b0, 16'd6);
        add(4'b0100, 2'b00, 1'b0, 4'b0100, S_DONE,  2'd2, 1'b0, 16'd6);
        add(4'b0000, 2'b00, 1'b0, 4'b0000, S_IDLE,  2'd2, 1'b0, 16'd6);
        // Illegal op ignored, non-owner request ignored, abort beats op.
        add(4'b0001, 2'b00, 1'b0, 4'b0001, S_GRANT, 2'd0, 1'b0, 16'd6);
        add(4'b0001, 2'b11, 1'b0, 4'b0001, S_GRANT, 2'd0, 1'b0, 16'd6);
        add(4'b1001, 2'b11, 1'b0, 4'b0001, S_GRANT, 2'd0, 1'b0, 16'd6);
        add(4'b0000, 2'b01, 1'b0, 4'b0000, S_IDLE,  2'd0, 1'b0, 16'd6);
        // Abort during transfer leaves the count alone.
        add(4'b1000, 2'b00, 1'b0, 4'b1000, S_GRANT, 2'd3, 1'b0, 16'd6);
        add(4'b1000, 2'b10, 1'b0, 4'b1000, S_XFER,  2'd3, 1'b0, 16'd6);
        add(4'b0000, 2'b00, 1'b0, 4'b0000, S_IDLE,  2'd3, 1'b0, 16'd6);

        req = 4'b0000; op = 2'b00; signal = 1'b0; reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_grant",   32'(grant),      32'h0);
        chk("reset_state",   32'(state),      32'(S_IDLE));
        chk("reset_owner",   32'(owner),      32'h0);
        chk("reset_timeout", 32'(timeout),    32'h0);
        chk("reset_count",   32'(xfer_count), 32'h0);
        #10 reset = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req; op = vecs[i].op; signal = vecs[i].signal;
            @(posedge clk); #1;
            chk($sformatf("v%0d_grant", i),   32'(grant),      32'(vecs[i].grant));
            chk($sformatf("v%0d_state", i),   32'(state),      32'(vecs[i].state));
            chk($sformatf("v%0d_owner", i),   32'(owner),      32'(vecs[i].owner));
            chk($sformatf("v%0d_timeout", i), 32'(timeout),    32'(vecs[i].timeout));
            chk($sformatf("v%0d_count", i),   32'(xfer_count), 32'(vecs[i].count));
        end

        // Watchdog: idle grant on requester 1 revoked after 16 GRANT cycles.
        req = 4'b0010; op = 2'b00; signal = 1'b0;
        @(posedge clk); #1;
        chk("wd_entry_state", 32'(state), 32'(S_GRANT));
        chk("wd_entry_owner", 32'(owner), 32'd1);
        req = 4'b0110;
        gcycles = 1;
        pulses  = 0;
        for (int i = 0; i < 40 && state == S_GRANT; i++) begin
            @(posedge clk); #1;
            if (timeout) pulses++;
            if (state == S_GRANT) gcycles++;
        end
        chk("wd_grant_cycles", 32'(gcycles),    32'd16);
        chk("wd_pulse_count",  32'(pulses),     32'd1);
        chk("wd_state",        32'(state),      32'(S_IDLE));
        chk("wd_grant",        32'(grant),      32'h0);
        chk("wd_timeout",      32'(timeout),    32'h1);
        chk("wd_count",        32'(xfer_count), 32'd6);
        @(posedge clk); #1;
        chk("wd_pulse_end",    32'(timeout),    32'h0);
        chk("wd_next_grant",   32'(grant),      32'b0100);
        chk("wd_next_state",   32'(state),      32'(S_GRANT));

        // Asynchronous reset in the middle of a transfer.
        op = 2'b01;
        @(posedge clk); #1;
        chk("ar_pre_state", 32'(state), 32'(S_XFER));
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("ar_grant", 32'(grant),      32'h0);
        chk("ar_state", 32'(state),      32'(S_IDLE));
        chk("ar_count", 32'(xfer_count), 32'h0);
        chk("ar_owner", 32'(owner),      32'h0);
        @(negedge clk);
        reset = 1'b0; req = 4'b1111; op = 2'b00;
        @(posedge clk); #1;
        chk("ar_first_grant", 32'(grant), 32'b0001);
        chk("ar_first_owner", 32'(owner), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
